// File: rtl/gmsk_pkg.sv
// Shared constants for the GMSK receive chain: phase-error codes, nominal rates, lock window.
package gmsk_pkg;

  localparam logic [1:0] PHERR_NONE    = 2'b00;
  localparam logic [1:0] PHERR_RETARD  = 2'b01;
  localparam logic [1:0] PHERR_ADVANCE = 2'b10;

  localparam int unsigned DEFAULT_OSR = 8;
  localparam int unsigned BR          = 100;
  localparam int unsigned SAMPLE_RATE = 800;
  // Transitions within +/-LOCK_WIN samples of phase 0 still count as on-time.
  localparam int unsigned LOCK_WIN    = 1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/bit_sync_lock_det.sv
// Lock detector: counts consecutive good bit periods and flags lock once LOCK_BITS is reached.
module bit_sync_lock_det #(
  parameter int unsigned LOCK_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic wrap,
  input  logic good,
  output logic locked
);

  localparam logic [7:0] LockMax = 8'(LOCK_BITS);

  logic [7:0] score_q, score_d;
  logic       locked_q;

  always_comb begin
    score_d = score_q;
    if (wrap) begin
      if (!good) begin
        score_d = '0;
      end else if (score_q != LockMax) begin
        score_d = score_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      score_q  <= score_d;
      locked_q <= (score_d == LockMax);
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/gmsk_bit_sync.sv
// Bit-timing recovery by transition tracking on OSR-oversampled hard decisions.
// Define MAJORITY_VOTE_EN for a 2-of-3 decision centred one sample later.
module gmsk_bit_sync
  import gmsk_pkg::*;
#(
  parameter int unsigned OSR       = DEFAULT_OSR,
  parameter int unsigned LOCK_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_in,
  input  logic       sample_valid,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       locked,
  output logic [1:0] phase_err
);

  localparam int unsigned PH_W = $clog2(OSR);
  localparam int unsigned PW1  = PH_W + 1;
  localparam int unsigned HALF = OSR / 2;

  localparam logic [PH_W-1:0] PhEarlyLo = PH_W'(1);
  localparam logic [PH_W-1:0] PhEarlyHi = PH_W'(HALF - 1);
  localparam logic [PH_W-1:0] PhLateLo  = PH_W'(HALF + 1);
  localparam logic [PH_W-1:0] PhLast    = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PhWinLo   = PH_W'(LOCK_WIN);
  localparam logic [PH_W-1:0] PhWinHi   = PH_W'(OSR - LOCK_WIN);
`ifdef MAJORITY_VOTE_EN
  localparam logic [PH_W-1:0] PhDec     = PH_W'(HALF + 1);
`else
  localparam logic [PH_W-1:0] PhDec     = PH_W'(HALF);
`endif

  logic [PH_W-1:0] ph_q, ph_d, ph_skip, ph_inc;
  logic [PH_W:0]   ph_p2, ph_sub;
  logic            prev_q, corr_done_q, bad_q;
  logic            bit_q, bit_valid_q;
  logic [1:0]      phase_err_q;
  logic            trans, early, late, skip_wrap, wrap, bad_now, good, dec_bit;

`ifdef MAJORITY_VOTE_EN
  // Oldest window tap is never read, so only the two most recent samples are kept.
  logic [1:0] win_q;
  assign dec_bit = maj3({win_q, sample_in});
`else
  assign dec_bit = sample_in;
`endif

  always_comb begin
    trans     = sample_in ^ prev_q;
    early     = trans && !corr_done_q && (ph_q >= PhEarlyLo) && (ph_q <= PhEarlyHi);
    late      = trans && !corr_done_q && (ph_q >= PhLateLo);
    ph_inc    = (ph_q == PhLast) ? '0 : ph_q + PH_W'(1);
    ph_p2     = {1'b0, ph_q} + PW1'(2);
    ph_sub    = ph_p2 - PW1'(OSR);
    skip_wrap = (ph_p2 >= PW1'(OSR));
    ph_skip   = skip_wrap ? ph_sub[PH_W-1:0] : ph_p2[PH_W-1:0];
    ph_d      = early ? ph_q : (late ? ph_skip : ph_inc);
    // A skip from the top of the period passes through 0 and closes the period too.
    wrap      = late ? skip_wrap : (!early && (ph_q == PhLast));
    bad_now   = trans && (ph_q > PhWinLo) && (ph_q < PhWinHi);
    good      = !(bad_q || bad_now);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q        <= '0;
      prev_q      <= 1'b0;
      corr_done_q <= 1'b0;
      bad_q       <= 1'b0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      phase_err_q <= PHERR_NONE;
`ifdef MAJORITY_VOTE_EN
      win_q       <= '0;
`endif
    end else begin
      bit_valid_q <= sample_valid && (ph_q == PhDec);
      if (sample_valid) begin
        ph_q        <= ph_d;
        prev_q      <= sample_in;
        corr_done_q <= wrap ? 1'b0 : (corr_done_q || early || late);
        bad_q       <= wrap ? 1'b0 : (bad_q || bad_now);
        phase_err_q <= early ? PHERR_RETARD : (late ? PHERR_ADVANCE : PHERR_NONE);
        if (ph_q == PhDec) bit_q <= dec_bit;
`ifdef MAJORITY_VOTE_EN
        win_q       <= {win_q[0], sample_in};
`endif
      end
    end
  end

  bit_sync_lock_det #(
    .LOCK_BITS(LOCK_BITS)
  ) u_lock_det (
    .clk   (clk),
    .rst   (rst),
    .wrap  (sample_valid && wrap),
    .good  (good),
    .locked(locked)
  );

  assign bit_out   = bit_q;
  assign bit_valid = bit_valid_q;
  assign phase_err = phase_err_q;

endmodule

// File: tb/tb_gmsk_bit_sync.sv
// Scoreboard bench for gmsk_bit_sync: expected bits queued at stimulus time, popped by a monitor.
module tb_gmsk_bit_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_in = 1'b0;
  logic       sample_valid = 1'b0;
  logic       bit_out, bit_valid, locked;
  logic [1:0] phase_err;

  int checks = 0;
  int errors = 0;
  int n_ret  = 0;
  int n_adv  = 0;
  logic exp_q[$];

  gmsk_bit_sync #(
    .OSR      (8),
    .LOCK_BITS(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .locked      (locked),
    .phase_err   (phase_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every bit_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bit_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bit_extra: bit_valid with bit_out=%0d but no bit expected at %0t",
                 bit_out, $time);
      end else begin
        chk("bit_out", 8'(bit_out), 8'(exp_q.pop_front()));
      end
    end
  end

  task automatic samp(input logic s);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = s;
    @(negedge clk);
    sample_valid = 1'b0;
    if (phase_err == 2'b01) n_ret++;
    else if (phase_err == 2'b10) n_adv++;
  endtask

  task automatic send_bit(input logic b);
    exp_q.push_back(b);
    repeat (8) samp(b);
  endtask

  task automatic check_reset_outputs();
    chk("rst_bit_out", 8'(bit_out), 8'd0);
    chk("rst_bit_valid", 8'(bit_valid), 8'd0);
    chk("rst_locked", 8'(locked), 8'd0);
    chk("rst_phase_err", 8'(phase_err), 8'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    n_ret = 0;
    n_adv = 0;
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk);
    chk(name, 8'(exp_q.size()), 8'd0);
    exp_q.delete();
  endtask

  initial begin
    do_reset();

    // Aligned 1010...: lock on the 16th wrap, never a correction.
    for (int k = 0; k < 16; k++) begin
      send_bit(~k[0]);
      if (k == 14) chk("lock_after_15", 8'(locked), 8'd0);
      if (k == 15) chk("lock_after_16", 8'(locked), 8'd1);
    end
    chk("aligned_retards", 8'(n_ret), 8'd0);
    chk("aligned_advances", 8'(n_adv), 8'd0);

    // 40 zero samples: five zero bits, lock held.
    repeat (5) send_bit(1'b0);
    chk("zeros_locked", 8'(locked), 8'd1);

    // One bit with its transition mid-period breaks lock at the next wrap.
    exp_q.push_back(1'b1);
    repeat (4) samp(1'b0);
    repeat (4) samp(1'b1);
    chk("bad_bit_unlock", 8'(locked), 8'd0);
    for (int k = 0; k < 16; k++) begin
      send_bit(k[0]);
      if (k == 14) chk("relock_after_15", 8'(locked), 8'd0);
      if (k == 15) chk("relock_after_16", 8'(locked), 8'd1);
    end
    drain("aligned_count");

    // Reset mid-bit: immediate clear, next bit starts a fresh period.
    repeat (3) samp(1'b0);
    do_reset();
    send_bit(1'b0);
    drain("midbit_count");

    // Stream late by 2 samples: one retard per bit for two bits.
    do_reset();
    repeat (2) samp(1'b0);
    for (int k = 0; k < 6; k++) send_bit(~k[0]);
    chk("late2_retards", 8'(n_ret), 8'd2);
    chk("late2_advances", 8'(n_adv), 8'd0);
    drain("late2_count");

    // Transitions at ph=6: two skips, first partial bit decided as 0.
    do_reset();
    exp_q.push_back(1'b0);
    repeat (6) samp(1'b0);
    for (int k = 0; k < 6; k++) send_bit(~k[0]);
    chk("early6_advances", 8'(n_adv), 8'd2);
    chk("early6_retards", 8'(n_ret), 8'd0);
    drain("early6_count");

    // Single-sample glitch at ph=4 inside a '1' bit.
    do_reset();
    send_bit(1'b0);
`ifdef MAJORITY_VOTE_EN
    exp_q.push_back(1'b1);
`else
    exp_q.push_back(1'b0);
`endif
    repeat (4) samp(1'b1);
    samp(1'b0);
    repeat (3) samp(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    drain("glitch_count");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
